instr_entry: RTL and testbench

INSTR_ENTRY -- requirements
Module: instr_entry

---
 rtl/instr_entry.sv | 140 ++++++++++++++
 tb/tb_instr_entry.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_entry.sv
// Hex-keypad instruction entry: assembles four nibbles into a 16-bit word,
// then issues a handshaked write to instruction memory at an auto-incrementing
// address. A write that is not acknowledged within TIMEOUT cycles parks the
// block in ERROR until Clear or Reset.
module instr_entry #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        NibbleIn,
    input  logic              Enter,
    input  logic              SetAddr,
    input  logic              Clear,
    input  logic              WrAck,
    output logic              WrReq,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [15:0]       WrData,
    output logic [15:0]       Word,
    output logic [2:0]        Count,
    output logic [1:0]        State,
    output logic              Err
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        ERROR   = 2'd2
    } state_t;

    // Wait counter only has to reach TIMEOUT-1, so size it to hold TIMEOUT.
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  WAIT_END = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [15:0]         word;
    logic [2:0]          count;
    logic [CNT_W-1:0]    wait_cnt;
    logic                wr_req;
    logic                err;
    logic                enter_q;
    logic                set_addr_q;

    logic                enter_edge;
    logic                set_addr_edge;

    // Rising-edge pulses of the level inputs against last cycle's sample.
    assign enter_edge    = Enter   & ~enter_q;
    assign set_addr_edge = SetAddr & ~set_addr_q;

    // Edge-detect history: always tracks the inputs so edges seen in WRITE
    // or ERROR are consumed rather than held back for later.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            enter_q    <= 1'b0;
            set_addr_q <= 1'b0;
        end else begin
            enter_q    <= Enter;
            set_addr_q <= SetAddr;
        end
    end

    // Entry FSM with registered outputs; priority is
    // Reset > Clear > WrAck/timeout > SetAddr edge > Enter edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= COLLECT;
            addr     <= '0;
            word     <= '0;
            count    <= '0;
            wait_cnt <= '0;
            wr_req   <= 1'b0;
            err      <= 1'b0;
        end else if (Clear) begin
            state    <= COLLECT;
            word     <= '0;
            count    <= '0;
            wait_cnt <= '0;
            wr_req   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (set_addr_edge) begin
                        // SetAddr beats a simultaneous Enter; the nibble is dropped.
                        addr  <= word[ADDR_W-1:0];
                        count <= '0;
                    end else if (enter_edge) begin
                        word <= {word[11:0], NibbleIn};
                        if (count == 3'd3) begin
                            count    <= 3'd4;
                            state    <= WRITE;
                            wait_cnt <= '0;
                            wr_req   <= 1'b1;
                        end else begin
                            count <= count + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (WrAck) begin
                        // Acknowledge wins over a timeout expiring this cycle.
                        addr   <= addr + ADDR_W'(1);
                        count  <= '0;
                        wr_req <= 1'b0;
                        state  <= COLLECT;
                    end else if (wait_cnt == WAIT_END) begin
                        wr_req <= 1'b0;
                        err    <= 1'b1;
                        state  <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ERROR: begin
                    // Hold everything; only Clear or Reset leave this state.
                    err <= 1'b1;
                end
                default: begin
                    state  <= COLLECT;
                    wr_req <= 1'b0;
                    err    <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping: everything visible is a direct register copy.
    assign WrReq  = wr_req;
    assign WrAddr = addr;
    assign WrData = word;
    assign Word   = word;
    assign Count  = count;
    assign State  = state;
    assign Err    = err;

endmodule

// File: tb/tb_instr_entry.sv
// Directed bench for instr_entry with TIMEOUT shortened to 4.
module tb_instr_entry;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [3:0]        NibbleIn;
    logic              Enter;
    logic              SetAddr;
    logic              Clear;
    logic              WrAck;
    logic              WrReq;
    logic [ADDR_W-1:0] WrAddr;
    logic [15:0]       WrData;
    logic [15:0]       Word;
    logic [2:0]        Count;
    logic [1:0]        State;
    logic              Err;

    int checks = 0;
    int errors = 0;

    instr_entry #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .NibbleIn (NibbleIn),
        .Enter    (Enter),
        .SetAddr  (SetAddr),
        .Clear    (Clear),
        .WrAck    (WrAck),
        .WrReq    (WrReq),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Word     (Word),
        .Count    (Count),
        .State    (State),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clean Enter pulse: one cycle high, one cycle low.
    task automatic enter_nibble(input logic [3:0] n);
        NibbleIn = n;
        Enter    = 1'b1;
        step();
        Enter    = 1'b0;
        step();
    endtask

    initial begin
        Reset = 1'b1; NibbleIn = '0; Enter = 1'b0; SetAddr = 1'b0;
        Clear = 1'b0; WrAck = 1'b0;
        step(); step();
        Reset = 1'b0;
        step();

        // Reset state
        check("rst_state", State,  0);
        check("rst_word",  Word,   16'h0000);
        check("rst_count", Count,  0);
        check("rst_wrreq", WrReq,  0);
        check("rst_addr",  WrAddr, 0);
        check("rst_err",   Err,    0);

        // Four nibbles assemble a word and launch a write
        enter_nibble(4'h1); enter_nibble(4'h2); enter_nibble(4'h3); enter_nibble(4'h4);
        check("w1_word",   Word,   16'h1234);
        check("w1_count",  Count,  4);
        check("w1_wrreq",  WrReq,  1);
        check("w1_addr",   WrAddr, 0);
        check("w1_data",   WrData, 16'h1234);
        check("w1_state",  State,  1);

        // Enter/SetAddr edges during WRITE are ignored
        SetAddr = 1'b1; NibbleIn = 4'h9; Enter = 1'b1;
        step();
        SetAddr = 1'b0; Enter = 1'b0;
        check("w1_ign_word", Word,   16'h1234);
        check("w1_ign_addr", WrAddr, 0);

        // Acknowledge completes the write
        WrAck = 1'b1;
        step();
        WrAck = 1'b0;
        check("ack_wrreq", WrReq,  0);
        check("ack_addr",  WrAddr, 1);
        check("ack_count", Count,  0);
        check("ack_state", State,  0);
        check("ack_word",  Word,   16'h1234);

        // Enter held for 10 cycles enters exactly one nibble
        NibbleIn = 4'h5; Enter = 1'b1;
        repeat (10) step();
        Enter = 1'b0;
        step();
        check("hold_count", Count, 1);
        check("hold_word",  Word,  16'h2345);

        // Clear from COLLECT keeps the address
        Clear = 1'b1; step(); Clear = 1'b0; step();
        check("clr_word", Word,   16'h0000);
        check("clr_addr", WrAddr, 1);

        // SetAddr loads 0xFF, then a write wraps the address to 0
        enter_nibble(4'hF); enter_nibble(4'hF);
        check("ff_word", Word, 16'h00FF);
        SetAddr = 1'b1; step(); SetAddr = 1'b0; step();
        check("sa_addr",  WrAddr, 8'hFF);
        check("sa_count", Count,  0);
        check("sa_word",  Word,   16'h00FF);
        enter_nibble(4'h1); enter_nibble(4'h2); enter_nibble(4'h3); enter_nibble(4'h4);
        check("ff_write_addr", WrAddr, 8'hFF);
        WrAck = 1'b1; step(); WrAck = 1'b0;
        check("wrap_addr",  WrAddr, 8'h00);
        check("wrap_state", State,  0);

        // Timeout: WRITE lasts TIMEOUT cycles without acknowledge, then ERROR
        enter_nibble(4'hA); enter_nibble(4'hB); enter_nibble(4'hC); enter_nibble(4'hD);
        step(); step();
        check("to_last_state", State, 1);
        check("to_last_wrreq", WrReq, 1);
        step();
        check("to_state", State,  2);
        check("to_err",   Err,    1);
        check("to_wrreq", WrReq,  0);
        check("to_addr",  WrAddr, 0);
        enter_nibble(4'h7);
        WrAck = 1'b1; step(); WrAck = 1'b0;
        check("err_hold_state", State, 2);
        check("err_hold_word",  Word,  16'hABCD);
        check("err_hold_count", Count, 4);
        Clear = 1'b1; step(); Clear = 1'b0;
        check("err_clr_state", State, 0);
        check("err_clr_word",  Word,  16'h0000);
        check("err_clr_err",   Err,   0);
        check("err_clr_count", Count, 0);
        check("err_clr_addr",  WrAddr, 0);
        step();

        // Clear beats a simultaneous Enter edge
        enter_nibble(4'h1); enter_nibble(4'h2);
        check("pc_word", Word, 16'h0012);
        Clear = 1'b1; Enter = 1'b1; NibbleIn = 4'h9;
        step();
        Clear = 1'b0; Enter = 1'b0;
        step();
        check("ce_count", Count, 0);
        check("ce_word",  Word,  16'h0000);
        enter_nibble(4'hA);
        check("ce_next_word",  Word,  16'h000A);
        check("ce_next_count", Count, 1);

        // SetAddr beats a simultaneous Enter edge
        NibbleIn = 4'h3; Enter = 1'b1; SetAddr = 1'b1;
        step();
        Enter = 1'b0; SetAddr = 1'b0;
        step();
        check("se_addr",  WrAddr, 8'h0A);
        check("se_word",  Word,   16'h000A);
        check("se_count", Count,  0);

        // WrAck on the timeout-expiry cycle wins
        enter_nibble(4'h1); enter_nibble(4'h2); enter_nibble(4'h3); enter_nibble(4'h4);
        step(); step();
        WrAck = 1'b1; step(); WrAck = 1'b0;
        check("race_state", State,  0);
        check("race_err",   Err,    0);
        check("race_addr",  WrAddr, 8'h0B);

        // WrAck outside WRITE is ignored
        WrAck = 1'b1; step(); step(); WrAck = 1'b0;
        check("ack_idle_addr",  WrAddr, 8'h0B);
        check("ack_idle_state", State,  0);

        // Reset mid-write drops WrReq and does not increment the address
        enter_nibble(4'h5); enter_nibble(4'h6); enter_nibble(4'h7); enter_nibble(4'h8);
        check("mw_wrreq_pre", WrReq, 1);
        Reset = 1'b1; WrAck = 1'b1;
        step();
        Reset = 1'b0; WrAck = 1'b0;
        check("mw_wrreq", WrReq,  0);
        check("mw_state", State,  0);
        check("mw_addr",  WrAddr, 0);
        check("mw_word",  Word,   16'h0000);
        check("mw_count", Count,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
